// File: rtl/cache_refill_pkg.sv
// Shared definitions for the cache line-fill engine.
//   - default geometry (set index, word-in-line, memory address, tag widths)
//   - refill FSM state encoding
//   - tag-entry packing helper: {valid, dirty, tag}
package cache_refill_pkg;

    localparam int INDEX_W_D = 6;
    localparam int WORD_W_D  = 3;
    localparam int MEM_AW_D  = 10;
    localparam int TAG_W_D   = 21;

    // Byte offset of a word is 2 bits, so line offset = WORD_W + 2 bits.
    localparam int BYTE_OFS_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } refill_state_t;

    // Freshly refilled lines are always clean and valid.
    function automatic logic [1:0] tag_flags_fill();
        return 2'b10; // {valid=1, dirty=0}
    endfunction

endpackage

// File: rtl/cache_refill_pipe.sv
// refill_pipe: STAGES-deep delay line carrying {valid, word index} of each
// issued memory read so that it emerges exactly when the read data returns.
// Ports:
//   clk, rst  - clock, synchronous active-low clear
//   in_vld    - read issued this cycle
//   in_k      - word index of the issued read
//   out_vld   - read data for out_k is on the memory bus this cycle
//   out_k     - word index matching the returning data
module refill_pipe #(
    parameter int STAGES = 1,
    parameter int KW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [KW-1:0] in_k,
    output logic          out_vld,
    output logic [KW-1:0] out_k
);

    logic [STAGES:1]         vld_pipe;
    logic [STAGES:1][KW-1:0] k_pipe;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_pipe <= '0;
            k_pipe   <= '0;
        end else begin
            vld_pipe[1] <= in_vld;
            k_pipe[1]   <= in_k;
            for (int i = 2; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                k_pipe[i]   <= k_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[STAGES];
    assign out_k   = k_pipe[STAGES];

endmodule

// File: rtl/cache_refill.sv
// cache_refill: line-fill engine. On an accepted start it reads the 8-word
// line containing addr from main memory (one word per cycle), writes each
// word into cache data RAM as it returns, then writes the tag entry
// {valid=1, dirty=0, tag} together with the last data word and pulses done.
// Ports:
//   clk, rst         - clock, synchronous active-low reset
//   addr, start      - miss address (sampled on accepted start), request
//   busy, done       - busy from cycle after accept through done; done pulse
//   main_mem_re/addr - registered read strobe / word address {line, k}
//   main_mem_data    - read data, valid MEM_LAT cycles after main_mem_re
//   cache_data_*     - data RAM write: we, {index, k}, data pass-through
//   cache_tag_*      - tag RAM write: we, index, {valid, dirty, tag}
module cache_refill
    import cache_refill_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_D,
    parameter int WORD_W  = WORD_W_D,
    parameter int MEM_AW  = MEM_AW_D,
    parameter int TAG_W   = TAG_W_D,
    parameter int MEM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               addr,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      main_mem_re,
    output logic [MEM_AW-1:0]         main_mem_addr,
    input  logic [31:0]               main_mem_data,
    output logic                      cache_data_we,
    output logic [INDEX_W+WORD_W-1:0] cache_data_addr,
    output logic [31:0]               cache_data_out,
    output logic                      cache_tag_we,
    output logic [INDEX_W-1:0]        cache_tag_index,
    output logic [TAG_W+1:0]          cache_tag_out
);

    localparam int OFS_W  = WORD_W + BYTE_OFS_W;
    localparam int LINE_W = 32 - OFS_W;
    localparam int BASE_W = MEM_AW - WORD_W;
    localparam logic [WORD_W-1:0] K_LAST = '1;

    refill_state_t     state, state_n;
    logic [WORD_W-1:0] k_q, k_n, k_inc;
    logic              re_q, re_n;
    logic [MEM_AW-1:0] maddr_q, maddr_n;
    logic [LINE_W-1:0] line_q, line_n;   // latched line address (addr[31:OFS_W])

    logic              p_vld;
    logic [WORD_W-1:0] p_k;
    logic              last_wr;

    logic [INDEX_W-1:0] index_q;
    logic [TAG_W-1:0]   tag_q;

    // Byte/word offset of the miss address is irrelevant to a full-line fill.
    logic unused_ofs;
    assign unused_ofs = ^addr[OFS_W-1:0];

    assign index_q = line_q[INDEX_W-1:0];
    assign tag_q   = line_q[LINE_W-1 -: TAG_W];
    assign k_inc   = k_q + 1'b1;

    // ---------------- next-state / next-output ----------------
    always_comb begin
        state_n = state;
        k_n     = k_q;
        re_n    = 1'b0;
        maddr_n = '0;
        line_n  = line_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_FETCH;
                    line_n  = addr[31:OFS_W];
                    k_n     = '0;
                    re_n    = 1'b1;
                    maddr_n = {addr[MEM_AW+1:OFS_W], {WORD_W{1'b0}}};
                end
            end
            ST_FETCH: begin
                // k_q is the word being read this cycle; stop after the last one.
                if (k_q == K_LAST) begin
                    state_n = ST_DRAIN;
                    k_n     = '0;
                end else begin
                    k_n     = k_inc;
                    re_n    = 1'b1;
                    maddr_n = {line_q[BASE_W-1:0], k_inc};
                end
            end
            ST_DRAIN: begin
                if (last_wr) state_n = ST_DONE;
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            k_q     <= '0;
            re_q    <= 1'b0;
            maddr_q <= '0;
            line_q  <= '0;
        end else begin
            state   <= state_n;
            k_q     <= k_n;
            re_q    <= re_n;
            maddr_q <= maddr_n;
            line_q  <= line_n;
        end
    end

    // Issued reads ride the delay line and pop out alongside their data.
    refill_pipe #(
        .STAGES (MEM_LAT),
        .KW     (WORD_W)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (re_q),
        .in_k    (k_q),
        .out_vld (p_vld),
        .out_k   (p_k)
    );

    assign last_wr = p_vld && (p_k == K_LAST);

    // ---------------- outputs ----------------
    assign busy            = (state != ST_IDLE);
    assign done            = (state == ST_DONE);
    assign main_mem_re     = re_q;
    assign main_mem_addr   = maddr_q;
    assign cache_data_we   = p_vld;
    assign cache_data_addr = p_vld ? {index_q, p_k} : '0;
    assign cache_data_out  = main_mem_data;
    assign cache_tag_we    = last_wr;
    assign cache_tag_index = last_wr ? index_q : '0;
    assign cache_tag_out   = last_wr ? {tag_flags_fill(), tag_q} : '0;

endmodule

// File: tb/tb_cache_refill.sv
// Testbench for cache_refill: two instances (MEM_LAT=1 and MEM_LAT=3) share
// the same stimulus. A reference model predicts every read, data write, tag
// write, done pulse and busy window per lane; a monitor compares each cycle.
module tb_cache_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr = 32'h0;

    logic [1:0]        busy, done, re, we, tag_we;
    logic [1:0][9:0]   mem_addr;
    logic [1:0][31:0]  mem_data, data_out;
    logic [1:0][8:0]   data_addr;
    logic [1:0][5:0]   tag_idx;
    logic [1:0][22:0]  tag_out;

    always #5 clk = ~clk;

    cache_refill #(.MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .addr(addr), .start(start),
        .busy(busy[0]), .done(done[0]),
        .main_mem_re(re[0]), .main_mem_addr(mem_addr[0]), .main_mem_data(mem_data[0]),
        .cache_data_we(we[0]), .cache_data_addr(data_addr[0]), .cache_data_out(data_out[0]),
        .cache_tag_we(tag_we[0]), .cache_tag_index(tag_idx[0]), .cache_tag_out(tag_out[0])
    );

    cache_refill #(.MEM_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .addr(addr), .start(start),
        .busy(busy[1]), .done(done[1]),
        .main_mem_re(re[1]), .main_mem_addr(mem_addr[1]), .main_mem_data(mem_data[1]),
        .cache_data_we(we[1]), .cache_data_addr(data_addr[1]), .cache_data_out(data_out[1]),
        .cache_tag_we(tag_we[1]), .cache_tag_index(tag_idx[1]), .cache_tag_out(tag_out[1])
    );

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t rd_q [2][$];
    ev_t wr_q [2][$];
    ev_t tg_q [2][$];
    int  dn_q [2][$];
    int  free_at [2] = '{0, 0};
    int  busy_lo [2] = '{-1, -1};
    int  busy_hi [2] = '{-1, -1};

    // Main memory: random contents, reads return after a fixed latency.
    logic [31:0] mem [0:1023];
    logic        mp_v [2][0:3] = '{default: 1'b0};
    logic [9:0]  mp_a [2][0:3] = '{default: 10'h0};
    assign mem_data[0] = mp_v[0][1] ? mem[mp_a[0][1]] : 32'h0;
    assign mem_data[1] = mp_v[1][3] ? mem[mp_a[1][3]] : 32'h0;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit fin = 1'b0;

    function automatic int lat(input int l);
        return (l == 0) ? 1 : 3;
    endfunction

    task automatic check(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d cyc %0d: got %h expected %h", nm, l, cyc, act, exp);
        end
    endtask

    // Monitor + model + memory, all on the falling edge (away from DUT updates).
    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            bit e;
            e = (rd_q[l].size() > 0) && (rd_q[l][0].cyc == cyc);
            check("mem_re", l, 32'(re[l]), 32'(e));
            if (e) begin
                check("mem_addr", l, 32'(mem_addr[l]), rd_q[l][0].a);
                void'(rd_q[l].pop_front());
            end else check("mem_addr_idle", l, 32'(mem_addr[l]), 32'h0);

            e = (wr_q[l].size() > 0) && (wr_q[l][0].cyc == cyc);
            check("data_we", l, 32'(we[l]), 32'(e));
            if (e) begin
                check("data_addr", l, 32'(data_addr[l]), wr_q[l][0].a);
                check("data_val", l, data_out[l], wr_q[l][0].d);
                void'(wr_q[l].pop_front());
            end else check("data_addr_idle", l, 32'(data_addr[l]), 32'h0);

            e = (tg_q[l].size() > 0) && (tg_q[l][0].cyc == cyc);
            check("tag_we", l, 32'(tag_we[l]), 32'(e));
            if (e) begin
                check("tag_index", l, 32'(tag_idx[l]), tg_q[l][0].a);
                check("tag_entry", l, 32'(tag_out[l]), tg_q[l][0].d);
                void'(tg_q[l].pop_front());
            end

            e = (dn_q[l].size() > 0) && (dn_q[l][0] == cyc);
            check("done", l, 32'(done[l]), 32'(e));
            if (e) void'(dn_q[l].pop_front());

            check("busy", l, 32'(busy[l]), 32'((cyc > busy_lo[l]) && (cyc <= busy_hi[l])));
        end

        // Reference model: react to this cycle's inputs.
        for (int l = 0; l < 2; l++) begin
            if (!rst) begin
                rd_q[l].delete();
                wr_q[l].delete();
                tg_q[l].delete();
                dn_q[l].delete();
                busy_hi[l] = cyc;
                free_at[l] = cyc + 1;
            end else if (start && cyc >= free_at[l]) begin
                int line_word, index, L;
                L         = lat(l);
                line_word = int'((addr >> 5) % 128) * 8;   // first memory word of the line
                index     = int'((addr >> 5) % 64);
                for (int k = 0; k < 8; k++) begin
                    rd_q[l].push_back('{cyc + 1 + k, 32'(line_word + k), 32'h0});
                    wr_q[l].push_back('{cyc + 1 + k + L, 32'(index * 8 + k), mem[line_word + k]});
                end
                tg_q[l].push_back('{cyc + 8 + L, 32'(index), 32'h0040_0000 + (addr >> 11)});
                dn_q[l].push_back(cyc + 9 + L);
                busy_lo[l] = cyc;
                busy_hi[l] = cyc + 9 + L;
                free_at[l] = cyc + 10 + L;
            end
        end

        // Memory latency pipe: stage s holds the read issued s cycles ago.
        for (int l = 0; l < 2; l++) begin
            for (int s = 3; s >= 2; s--) begin
                mp_v[l][s] = mp_v[l][s-1];
                mp_a[l][s] = mp_a[l][s-1];
            end
            mp_v[l][1] = re[l];
            mp_a[l][1] = mem_addr[l];
        end

        cyc++;
        if (fin) begin
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // Single fill at 0x1A40: words 0x290.., index 0x12, tag 0x3.
        addr = 32'h0000_1A40; start = 1'b1; step(); start = 1'b0;
        repeat (16) step();

        // Second start during FETCH is ignored.
        addr = 32'h0000_1A40; start = 1'b1; step(); start = 1'b0;
        repeat (2) step();
        addr = 32'hFFFF_FFE0; start = 1'b1; step(); start = 1'b0;
        repeat (16) step();

        // Start held high: back-to-back fills, re-sampling addr each time.
        addr = 32'h0000_5A60; start = 1'b1;
        repeat (30) step();
        start = 1'b0;
        repeat (16) step();

        // Reset mid-fill, then a clean fill.
        addr = 32'h0003_0C20; start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
        rst = 1'b0; step(); rst = 1'b1;
        repeat (3) step();
        start = 1'b1; step(); start = 1'b0;
        repeat (16) step();

        // Last word of the address space: base 0x3F8, index 0x3F.
        addr = 32'hFFFF_FFFC; start = 1'b1; step(); start = 1'b0;
        repeat (16) step();

        // Random traffic with addr changes while busy and rare resets.
        repeat (800) begin
            start = ($urandom_range(0, 3) == 0);
            addr  = $urandom;
            rst   = ($urandom_range(0, 80) != 0);
            step();
        end
        start = 1'b0;
        rst   = 1'b1;
        repeat (20) step();
        fin = 1'b1;
        repeat (3) step();
    end

endmodule
